// File: rtl/approx_cmp_sequencer.sv
// Approximate pixel comparator sequencer: walks two WIDTH-bit operands two bits
// per cycle from the MSB pair down, stops on the first decisive pair, and can
// skip a runtime-selected number of LSB pairs. Valid/ready on both sides.
module approx_cmp_sequencer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned NP = WIDTH / 2,
  localparam int unsigned CW = $clog2(NP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    approx_pairs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    cycles
);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    stop_q, stop_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

  logic [CW-1:0]    stop_clamped;
  logic [1:0]       pair_x, pair_y;
  logic             slice_h, slice_l;

  // Current pair and the approximate slice; 10/10 and 01/01 report H on purpose.
  always_comb begin
    pair_x       = 2'(a_q >> {idx_q, 1'b0});
    pair_y       = 2'(b_q >> {idx_q, 1'b0});
    slice_h      = (pair_x[0] & ~pair_y[1]) | (pair_x[1] & ~pair_y[1]) |
                   (pair_x[1] & ~pair_y[0]);
    slice_l      = ~pair_x[1] & pair_y[1];
    stop_clamped = (approx_pairs > CW'(NP)) ? CW'(NP) : approx_pairs;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    stop_d   = stop_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          stop_d   = stop_clamped;
          idx_d    = CW'(NP - 1);
          cycles_d = '0;
          if (stop_clamped == CW'(NP)) begin
            // Every pair skipped: nothing left to decide.
            eq_d    = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCompare;
          end
        end
      end
      StCompare: begin
        cycles_d = cycles_q + CW'(1);
        if (slice_h) begin
          gt_d    = 1'b1;
          state_d = StDone;
        end else if (slice_l) begin
          lt_d    = 1'b1;
          state_d = StDone;
        end else if (idx_q == stop_q) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      stop_q   <= '0;
      idx_q    <= '0;
      cycles_q <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      stop_q   <= stop_d;
      idx_q    <= idx_d;
      cycles_q <= cycles_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_approx_cmp_sequencer.sv
// Self-checking bench for approx_cmp_sequencer (WIDTH=8): directed vector table,
// reset-abort sequence, and randomized transactions against a pair-walk model.
module tb_approx_cmp_sequencer;

  localparam int W  = 8;
  localparam int NP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [CW-1:0] approx_pairs = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          gt, lt, eq;
  logic [CW-1:0] cycles;

  int total = 0;
  int passed = 0;

  // flags encoding used throughout: {gt, lt, eq} -> gt=4, lt=2, eq=1
  typedef struct {
    int a;
    int b;
    int ap;
    int hold;
    int flags;
    int cyc;
  } vec_t;

  vec_t vecs[11];

  approx_cmp_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .approx_pairs (approx_pairs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .gt           (gt),
    .lt           (lt),
    .eq           (eq),
    .cycles       (cycles)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Walk pairs MSB-first down to the stop pair, using the slice truth rules:
  // H when Y<=1 and X>=1, or Y==2 and X>=2; L when X<=1 and Y>=2.
  function automatic void model(input int x, input int y, input int ap,
                                output int flags, output int cyc);
    int stop;
    stop  = (ap > NP) ? NP : ap;
    cyc   = 0;
    flags = 1;
    for (int i = NP - 1; i >= stop; i--) begin
      int xp, yp;
      xp = (x >> (2 * i)) & 3;
      yp = (y >> (2 * i)) & 3;
      cyc++;
      if ((yp <= 1 && xp >= 1) || (yp == 2 && xp >= 2)) begin
        flags = 4;
        return;
      end
      if (xp <= 1 && yp >= 2) begin
        flags = 2;
        return;
      end
    end
  endfunction

  // One full transaction; lat counts clock edges from the accept edge inclusive.
  task automatic txn(input int ta, input int tb, input int tap, input int hold,
                     output int flags, output int cyc, output int lat);
    a            = 8'(ta);
    b            = 8'(tb);
    approx_pairs = 3'(tap);
    in_valid     = 1'b1;
    check("idle_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    // Post-accept changes must have no effect.
    in_valid     = 1'b0;
    a            = 8'($urandom);
    b            = 8'($urandom);
    approx_pairs = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < NP + 4) begin
      check("busy_in_ready", int'(in_ready), 0);
      check("busy_flags", int'({gt, lt, eq}), 0);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", int'(out_valid), 1);
    flags = int'({gt, lt, eq});
    cyc   = int'(cycles);
    check("flags_one_hot", $countones({gt, lt, eq}), 1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_flags", int'({gt, lt, eq}), flags);
      check("hold_cycles", int'(cycles), cyc);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", int'(out_valid), 0);
    check("post_flags", int'({gt, lt, eq}), 0);
    check("post_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int f, c, l, ef, ec, ta, tb, tap;

    vecs[0]  = '{'hC0, 'h40, 0, 0, 4, 1};
    vecs[1]  = '{'h40, 'h80, 0, 1, 2, 1};
    vecs[2]  = '{'h0F, 'h0F, 0, 5, 1, 4};
    vecs[3]  = '{'h1B, 'h1C, 0, 0, 4, 2};
    vecs[4]  = '{'h03, 'h0C, 2, 2, 1, 2};
    vecs[5]  = '{'hA5, 'h5A, 7, 0, 1, 0};
    vecs[6]  = '{'h00, 'h01, 0, 0, 1, 4};
    vecs[7]  = '{'h02, 'h03, 0, 1, 1, 4};
    vecs[8]  = '{'h08, 'h0C, 1, 0, 1, 3};
    vecs[9]  = '{'h80, 'h80, 0, 0, 4, 1};
    vecs[10] = '{'h00, 'hC0, 4, 3, 1, 0};

    // Reset values.
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_flags", int'({gt, lt, eq}), 0);
    check("reset_cycles", int'(cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].a, vecs[i].b, vecs[i].ap, vecs[i].hold, f, c, l);
      check($sformatf("vec%0d_flags", i), f, vecs[i].flags);
      check($sformatf("vec%0d_cycles", i), c, vecs[i].cyc);
      check($sformatf("vec%0d_latency", i), l, vecs[i].cyc + 1);
    end

    // Reset pulse mid-COMPARE aborts with no result.
    a = 8'h0F; b = 8'h0F; approx_pairs = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_flags", int'({gt, lt, eq}), 0);
    check("abort_cycles", int'(cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", int'(out_valid), 0);
      check("abort_idle", int'(in_ready), 1);
    end

    // Randomized transactions against the model.
    for (int i = 0; i < 150; i++) begin
      ta  = int'($urandom_range(0, 255));
      tb  = ($urandom_range(0, 1) == 1) ? (ta ^ (1 << $urandom_range(0, 7))) & 255
                                         : int'($urandom_range(0, 255));
      tap = int'($urandom_range(0, 7));
      model(ta, tb, tap, ef, ec);
      txn(ta, tb, tap, int'($urandom_range(0, 2)), f, c, l);
      check($sformatf("rnd%0d_flags a=%0h b=%0h ap=%0d", i, ta, tb, tap), f, ef);
      check($sformatf("rnd%0d_cycles", i), c, ec);
      check($sformatf("rnd%0d_latency", i), l, ec + 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
